// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gates-block BIST sequencer:
// FSM states, gate_out bit positions and the golden truth table.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int IDX_AND   = 0;
    localparam int IDX_OR    = 1;
    localparam int IDX_NOT_A = 2;
    localparam int IDX_NOT_B = 3;
    localparam int IDX_NAND  = 4;
    localparam int IDX_NOR   = 5;
    localparam int IDX_XOR   = 6;
    localparam int IDX_XNOR  = 7;

    // Entry index is {A,B}; entry 0 is the rightmost element.
    localparam logic [3:0][7:0] GOLDEN_LUT = {8'h83, 8'h5A, 8'h56, 8'hBC};

endpackage

// File: rtl/gate_bist_golden.sv
// Combinational golden lookup: expected 8-bit gates-block response for a 2-bit {A,B} vector.
// Zero latency; no flow control.
module gate_bist_golden
    import gate_bist_pkg::*;
(
    input  logic [1:0] vec,
    output logic [7:0] expected
);

    assign expected = GOLDEN_LUT[vec];

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: sweeps {A,B} over 00..11 PASSES times, compares gate_out with the golden table.
// Run length 4*PASSES*(SETTLE_CYCLES+1) cycles; start is ignored while busy. Macro GATE_BIST_LOG_EN adds first-failure capture.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       gate_out,
    output logic             drv_a,
    output logic             drv_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count
`ifdef GATE_BIST_LOG_EN
    ,
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic [7:0]       fail_bits
`endif
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       PASS_LAST   = 8'(PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q;
    logic [1:0]       vec_q;
    logic [3:0]       settle_q;
    logic [7:0]       pass_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic [7:0]       expected;
    logic             mismatch;

    gate_bist_golden u_golden (
        .vec      (vec_q),
        .expected (expected)
    );

    assign mismatch = (gate_out != expected);
    assign err_d    = (mismatch && (err_q != CNT_MAX)) ? err_q + CNT_ONE : err_q;

`ifdef GATE_BIST_LOG_EN
    logic       fail_valid_q;
    logic [1:0] fail_vec_q;
    logic [7:0] fail_bits_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
            fail_bits_q  <= 8'd0;
        end else if (state_q == IDLE && start) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
            fail_bits_q  <= 8'd0;
        end else if (state_q == CHECK && mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec_q;
            fail_bits_q  <= gate_out ^ expected;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
    assign fail_bits  = fail_bits_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= 2'd0;
            settle_q   <= 4'd0;
            pass_cnt_q <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q      <= '0;
                        pass_q     <= 1'b0;
                        vec_q      <= 2'd0;
                        pass_cnt_q <= 8'd0;
                        settle_q   <= 4'd0;
                        busy_q     <= 1'b1;
                        state_q    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= 4'd0;
                        state_q  <= CHECK;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                CHECK: begin
                    err_q <= err_d;
                    if (vec_q != 2'd3) begin
                        vec_q   <= vec_q + 2'd1;
                        state_q <= SETTLE;
                    end else if (pass_cnt_q != PASS_LAST) begin
                        vec_q      <= 2'd0;
                        pass_cnt_q <= pass_cnt_q + 8'd1;
                        state_q    <= SETTLE;
                    end else begin
                        // Verdict uses the count including this final comparison.
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drv_a     = vec_q[1];
    assign drv_b     = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three parameterisations driven by a behavioural gates model with injectable stuck-at faults.
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v;
    wire  [2:0] drv_a_v, drv_b_v, busy_v, done_v, pass_v;
    wire  [7:0] errw [3];
    wire  [1:0] err2;
    wire  [7:0] go   [3];
    logic [7:0] am   [3];
    logic [7:0] om   [3];

    int S_of [3] = '{2, 1, 2};
    int P_of [3] = '{1, 3, 2};
    int W_of [3] = '{8, 8, 2};

    int checks = 0;
    int errors = 0;

`ifdef GATE_BIST_LOG_EN
    wire [2:0] fvalid_v;
    wire [1:0] fvec  [3];
    wire [7:0] fbits [3];
`endif

    // Behavioural gates block: bit0 AND .. bit7 XNOR.
    function automatic logic [7:0] ref_gates(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_gates
        assign go[g] = (ref_gates(drv_a_v[g], drv_b_v[g]) & am[g]) | om[g];
    end
    assign errw[2] = {6'd0, err2};

    gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .gate_out(go[0]),
        .drv_a(drv_a_v[0]), .drv_b(drv_b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_count(errw[0])
`ifdef GATE_BIST_LOG_EN
        , .fail_valid(fvalid_v[0]), .fail_vec(fvec[0]), .fail_bits(fbits[0])
`endif
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(3), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .gate_out(go[1]),
        .drv_a(drv_a_v[1]), .drv_b(drv_b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_count(errw[1])
`ifdef GATE_BIST_LOG_EN
        , .fail_valid(fvalid_v[1]), .fail_vec(fvec[1]), .fail_bits(fbits[1])
`endif
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .gate_out(go[2]),
        .drv_a(drv_a_v[2]), .drv_b(drv_b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_count(err2)
`ifdef GATE_BIST_LOG_EN
        , .fail_valid(fvalid_v[2]), .fail_vec(fvec[2]), .fail_bits(fbits[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fault(input int d, input logic [7:0] a, input logic [7:0] o);
        am[d] = a;
        om[d] = o;
    endtask

    // One full run on DUT d, checked cycle by cycle against the sweep rules.
    task automatic run(input int d, input bit repulse);
        int S, P, W, n, mis, exp_err, first;
        logic [7:0] g, f, fb;
        logic [1:0] vv;
        S = S_of[d]; P = P_of[d]; W = W_of[d];
        n = 4 * P * (S + 1);
        mis = 0; first = -1; fb = 8'd0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            g = ref_gates(vv[1], vv[0]);
            f = (g & am[d]) | om[d];
            if (f != g) begin
                mis++;
                if (first < 0) begin
                    first = v;
                    fb = f ^ g;
                end
            end
        end
        exp_err = mis * P;
        if (exp_err > (1 << W) - 1) exp_err = (1 << W) - 1;

        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        for (int e = 0; e <= n; e++) begin
            if (e > 0) @(negedge clk);
            start_v[d] = (repulse && e == 3);
            if (e == 0) begin
                chk("start_err_clr", errw[d], 0);
                chk("start_pass_clr", pass_v[d], 0);
            end
            chk("run_busy", busy_v[d], 1);
            if (e < n) begin
                chk("run_drv", {drv_a_v[d], drv_b_v[d]}, (e / (S + 1)) % 4);
                chk("run_no_done", done_v[d], 0);
            end else begin
                chk("done_pulse", done_v[d], 1);
                chk("done_pass", pass_v[d], exp_err == 0);
                chk("done_err", errw[d], exp_err);
                chk("done_drv", {drv_a_v[d], drv_b_v[d]}, 3);
`ifdef GATE_BIST_LOG_EN
                chk("log_valid", fvalid_v[d], mis > 0);
                if (mis > 0) begin
                    chk("log_vec", fvec[d], first);
                    chk("log_bits", fbits[d], fb);
                end
`endif
            end
        end
        start_v[d] = 1'b0;
        @(negedge clk);
        chk("after_done_low", done_v[d], 0);
        chk("after_busy_low", busy_v[d], 0);
        chk("after_drv_hold", {drv_a_v[d], drv_b_v[d]}, 3);
        chk("after_pass_hold", pass_v[d], exp_err == 0);
        chk("after_err_hold", errw[d], exp_err);
    endtask

    initial begin
        rst = 1'b1;
        start_v = 3'b000;
        for (int d = 0; d < 3; d++) set_fault(d, 8'hFF, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", busy_v[d], 0);
            chk("rst_done", done_v[d], 0);
            chk("rst_pass", pass_v[d], 0);
            chk("rst_err", errw[d], 0);
            chk("rst_drv", {drv_a_v[d], drv_b_v[d]}, 0);
`ifdef GATE_BIST_LOG_EN
            chk("rst_log", {fvalid_v[d], fvec[d], fbits[d]}, 0);
`endif
        end

        run(0, 1'b0);                         // healthy gates
        set_fault(0, ~8'h40, 8'h00); run(0, 1'b0);   // XOR stuck at 0
        set_fault(1, 8'hFF, 8'h80);  run(1, 1'b0);   // XNOR stuck at 1, three sweeps
        set_fault(2, 8'h00, 8'h00);  run(2, 1'b0);   // all outputs low, counter saturates
        set_fault(0, 8'hFF, 8'h00);  run(0, 1'b1);   // start re-pulsed mid-run

        // Reset in the SETTLE phase of vector 2 with a nonzero count pending.
        set_fault(0, 8'hFF, 8'h01);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2 * (S_of[0] + 1)) @(negedge clk);
        chk("pre_rst_drv", {drv_a_v[0], drv_b_v[0]}, 2);
        chk("pre_rst_err", errw[0], 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy_v[0], 0);
        chk("mid_rst_drv", {drv_a_v[0], drv_b_v[0]}, 0);
        chk("mid_rst_err", errw[0], 0);
        for (int e = 0; e < 4 * P_of[0] * (S_of[0] + 1) + 4; e++) begin
            chk("mid_rst_no_done", done_v[0], 0);
            @(negedge clk);
        end

        // start held high: back-to-back runs, each separated by one IDLE cycle.
        set_fault(1, 8'hFF, 8'h00);
        begin
            int n;
            n = 4 * P_of[1] * (S_of[1] + 1);
            start_v[1] = 1'b1;
            @(negedge clk);
            for (int e = 0; e <= 3 * n + 4; e++) begin
                if (e > 0) @(negedge clk);
                chk("held_done", done_v[1], (e % (n + 2)) == n);
                chk("held_busy", busy_v[1], (e % (n + 2)) != n + 1);
                if ((e % (n + 2)) == n) chk("held_pass", pass_v[1], 1);
            end
            start_v[1] = 1'b0;
            @(negedge clk);
            chk("held_idle1", busy_v[1], 0);
            @(negedge clk);
            chk("held_idle2", busy_v[1], 0);
        end

        for (int i = 0; i < 6; i++) begin
            int d;
            logic [7:0] a, o;
            d = i % 3;
            a = ($urandom_range(0, 2) == 0) ? 8'hFF : ~(8'd1 << $urandom_range(0, 7));
            o = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'd1 << $urandom_range(0, 7));
            set_fault(d, a, o);
            run(d, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
